// File: rtl/x_oneshot_array.sv
// x_oneshot_array: per-channel retrigger-guarded one-shots with
// shared deadtime, optional pulse stretch and a saturating fire counter.
module x_oneshot_array #(
  parameter int NCH   = 8,
  parameter int NBITS = 4,
  parameter int CNTB  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   d,
  input  logic [NCH-1:0]   en,
  input  logic [NBITS-1:0] deadtime,
  input  logic             stretch,
  input  logic             cnt_clr,
  output logic [NCH-1:0]   q,
  output logic [NCH-1:0]   busy,
  output logic [CNTB-1:0]  fire_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           st_q [NCH];
  state_e           st_d [NCH];
  logic [NBITS-1:0] hc_q [NCH];
  logic [NBITS-1:0] hc_d [NCH];
  logic [NCH-1:0]   q_q, q_d;
  logic [NCH-1:0]   busy_q, busy_d;
  logic [NCH-1:0]   trig;
  logic [CNTB-1:0]  cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st_d[i]   = st_q[i];
      hc_d[i]   = hc_q[i];
      q_d[i]    = 1'b0;
      trig[i]   = 1'b0;
      busy_d[i] = 1'b0;
      case (st_q[i])
        IDLE: begin
          hc_d[i] = '0;
          if (d[i] && en[i]) begin
            trig[i] = 1'b1;
            st_d[i] = HOLD;
            hc_d[i] = deadtime;
            q_d[i]  = 1'b1;
          end
        end
        HOLD: begin
          // q follows the pre-decrement count so width is max(1,D)
          q_d[i] = stretch && (hc_q[i] > NBITS'(1));
          if (hc_q[i] != '0) begin
            hc_d[i] = hc_q[i] - NBITS'(1);
          end else if (!d[i]) begin
            st_d[i] = IDLE;
          end
        end
        default: begin
          st_d[i] = IDLE;
          hc_d[i] = '0;
        end
      endcase
      busy_d[i] = (st_d[i] == HOLD);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if ((|trig) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTB'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i] <= IDLE;
        hc_q[i] <= '0;
      end
      q_q    <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i] <= st_d[i];
        hc_q[i] <= hc_d[i];
      end
      q_q    <= q_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q        = q_q;
  assign busy     = busy_q;
  assign fire_cnt = cnt_q;

endmodule

// File: tb/tb_x_oneshot_array.sv
// tb_x_oneshot_array: scoreboard bench, expected vectors from an
// age-based channel model queued at drive time, popped after the edge.
module tb_x_oneshot_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  d, en;
  logic [3:0]  deadtime;
  logic        stretch, cnt_clr;
  logic [7:0]  q, busy;
  logic [15:0] fire_cnt;

  logic [7:0]  d2, en2;
  logic [3:0]  deadtime2;
  logic        stretch2, cnt_clr2;
  logic [7:0]  q2, busy2;
  logic [3:0]  fire_cnt2;

  always #5 clk = ~clk;

  x_oneshot_array #(.NCH(8), .NBITS(4), .CNTB(16)) u_dut (
    .clk(clk), .reset(reset), .d(d), .en(en),
    .deadtime(deadtime), .stretch(stretch), .cnt_clr(cnt_clr),
    .q(q), .busy(busy), .fire_cnt(fire_cnt)
  );

  x_oneshot_array #(.NCH(8), .NBITS(4), .CNTB(4)) u_dut4 (
    .clk(clk), .reset(reset), .d(d2), .en(en2),
    .deadtime(deadtime2), .stretch(stretch2), .cnt_clr(cnt_clr2),
    .q(q2), .busy(busy2), .fire_cnt(fire_cnt2)
  );

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  int nvec = 0;
  int nmis = 0;

  bit          mst [8];
  int          mk  [8];
  int          md  [8];
  logic [15:0] mcnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mst[i] = 1'b0;
      mk[i]  = 0;
      md[i]  = 0;
    end
    mcnt = '0;
  endtask

  // Channel state is described by age since trigger and latched D.
  task automatic model_push();
    exp_t e;
    bit   any;
    int   rem;
    any = 1'b0;
    e.q = '0;
    e.busy = '0;
    for (int i = 0; i < 8; i++) begin
      if (!mst[i]) begin
        if (d[i] && en[i]) begin
          mst[i] = 1'b1;
          mk[i]  = 0;
          md[i]  = int'(deadtime);
          e.q[i] = 1'b1;
          any    = 1'b1;
        end
      end else begin
        mk[i]++;
        rem = md[i] - (mk[i] - 1);
        if (rem < 0) rem = 0;
        e.q[i] = stretch && (rem > 1);
        if (rem == 0 && !d[i]) mst[i] = 1'b0;
      end
      e.busy[i] = mst[i];
    end
    if (cnt_clr) mcnt = '0;
    else if (any && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    e.cnt = mcnt;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("q", 32'(q), 32'(e.q));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("fire_cnt", 32'(fire_cnt), 32'(e.cnt));
  endtask

  task automatic idle(input int n);
    d = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  logic [15:0] c0;

  initial begin
    reset = 1'b1;
    d = '0; en = '0; deadtime = '0;
    stretch = 1'b0; cnt_clr = 1'b0;
    d2 = '0; en2 = '1; deadtime2 = '0;
    stretch2 = 1'b0; cnt_clr2 = 1'b0;
    model_reset();
    #3;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(fire_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // D=3 single pulses: spacing D+2, busy 4 clks
    en = '1; deadtime = 4'd3; stretch = 1'b0;
    for (int r = 0; r < 3; r++) begin
      d = 8'h01;
      step();
      idle(4);
    end
    // d pulsing every clk: retriggers blocked while holding
    for (int k = 0; k < 12; k++) begin
      d = {7'd0, k[0] == 1'b0};
      step();
    end
    idle(6);

    // D=3 stretched, d[2] high 10 clks
    stretch = 1'b1;
    d = 8'h04;
    for (int k = 0; k < 10; k++) step();
    idle(6);

    // D=0 stretched, d[1] toggling
    deadtime = 4'd0;
    for (int k = 0; k < 8; k++) begin
      d = (k % 2 == 0) ? 8'h02 : 8'h00;
      step();
    end
    idle(3);

    // all channels at once, then channel 5 alone
    deadtime = 4'd3; stretch = 1'b0;
    c0 = fire_cnt;
    d = 8'hFF;
    step();
    chk("all_q", 32'(q), 32'hFF);
    idle(9);
    d = 8'h20;
    step();
    chk("ch5_q", 32'(q), 32'h20);
    chk("cnt_plus2", 32'(fire_cnt), 32'(c0 + 16'd2));
    idle(6);

    // en gating and en drop during hold
    d = 8'h10; en = 8'hEF;
    step();
    chk("en0_q", 32'(q), 32'h00);
    en = 8'hFF; deadtime = 4'd5; stretch = 1'b1;
    step();
    d = '0; en = 8'h00; deadtime = 4'd0;
    for (int k = 0; k < 7; k++) step();
    en = 8'hFF;

    // random traffic with live stretch/deadtime/cnt_clr
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 8; i++) d[i] = ($urandom_range(0, 9) < 3);
      en = 8'($urandom) | 8'h0F;
      deadtime = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) stretch = ~stretch;
      cnt_clr = ($urandom_range(0, 29) == 0);
      step();
    end
    cnt_clr = 1'b0;
    idle(10);

    // async reset mid-hold
    deadtime = 4'd7; stretch = 1'b0;
    d = 8'h08;
    step();
    step();
    chk("pre_rst_busy", 32'(busy), 32'h08);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_q", 32'(q), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cnt", 32'(fire_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_rst_q", 32'(q), 32'h08);
    idle(12);

    // CNTB=4 saturation and clear priority
    for (int k = 0; k < 20; k++) begin
      d2 = 8'h01;
      @(posedge clk); #1;
      d2 = 8'h00;
      @(posedge clk); #1;
    end
    chk("sat_cnt", 32'(fire_cnt2), 32'd15);
    d2 = 8'h01; cnt_clr2 = 1'b1;
    @(posedge clk); #1;
    chk("clr_q", 32'(q2), 32'h01);
    chk("clr_cnt", 32'(fire_cnt2), 32'd0);
    d2 = '0; cnt_clr2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
